sram_port_arbiter: RTL and testbench
====================================

Name: sram_port_arbiter

Overview:
Two-requester controller for the single-port main SRAM, which has a 1-cycle synchronous read and no byte enables. It arbitrates instruction fetch against data load/store using round-robin on ties, and checks alignment and range. It sequences read-modify-write for sub-word stores and performs lane extraction with sign/zero extension for loads. It sits between the core's fetch/LSU ports and the sram instance.

Parameters:
XLEN, 64, data/word width in bits (32 or 64).
MEM_DEPTH, 262144, SRAM depth in words; AW = $clog2(MEM_DEPTH).
OFFW (localparam), $clog2(XLEN/8), byte-offset bits within a word.

Ports:
clk  in  1  clock.
resetn  in  1  reset.
imem_req  in  1  fetch request; level, held until imem_ready.
imem_addr  in  32  fetch byte address.
imem_ready  out  1  one-cycle response pulse.
imem_err  out  1  valid with imem_ready; misaligned or out-of-range.
imem_data  out  32  instruction; valid with imem_ready.
dmem_read_req  in  1  load request; level, held until dmem_ready.
dmem_write_req  in  1  store request; read_req has precedence if both are high.
dmem_addr  in  XLEN  byte address.
dmem_wdata  in  XLEN  store data, right-justified.
dmem_size  in  3  defs_pkg size code: BYTE/HALF/WORD/DOUBLE.
dmem_signed  in  1  sign-extend loads.
dmem_rdata  out  XLEN  load result; valid with dmem_ready, 0 otherwise.
dmem_ready  out  1  one-cycle response pulse.
dmem_err  out  1  valid with dmem_ready.
sram_we  out  1  SRAM write enable.
sram_addr  out  AW  SRAM word index.
sram_wdata  out  XLEN  SRAM write data.
sram_rdata  in  XLEN  SRAM read data, valid the cycle after the address is presented.

Behaviour:
- Clock and reset: single clock clk; reset resetn is asynchronous and active-low.
- Reset: state=IDLE, last_grant=INST (data wins the first tie), latched request registers cleared. All outputs are 0. sram_we is forced to 0 while resetn is low. A reset mid-operation drops the in-flight access: no write and no response.
- Addressing: little-endian. Word index = addr[OFFW +: AW]; offset = addr[OFFW-1:0].
- Out-of-range: any address bit above OFFW+AW-1 is set → error.
- Misaligned data access: offset not a multiple of the size in bytes → error. DOUBLE with XLEN=32 → error.
- Misaligned fetch: imem_addr[1:0]≠0 → error.
- States: IDLE, I_RESP, D_RESP, D_MERGE.
- Requests are sampled only in IDLE, and are ignored in response cycles.
- IDLE arbitration: only one side requesting → grant it. Both requesting → grant the side opposite last_grant, then update last_grant.
- On grant, latch owner, addr, size, signed, wdata, dir and err.
  - Error: no SRAM access (sram_we=0); go to I_RESP or D_RESP with err latched.
  - Fetch or load: drive sram_addr; go to I_RESP or D_RESP.
  - Full-word store (size matches XLEN): sram_we=1 with sram_wdata=wdata; go to D_RESP.
  - Sub-word store: drive a read of the word; go to D_MERGE.
- D_MERGE: sram_wdata = sram_rdata with the size-wide lane at the offset replaced by wdata low bits. sram_we=1 at the latched index; go to D_RESP.
- I_RESP: imem_ready=1; imem_data = 32-bit lane of sram_rdata at addr[OFFW-1:2]; imem_err=err (data 0 if err); go to IDLE.
- D_RESP: dmem_ready=1; dmem_err=err.
  - Load: dmem_rdata = lane at offset, sign-extended if signed, else zero-extended. DOUBLE/full-word is passed through.
  - Store or error: dmem_rdata=0.
  - Go to IDLE.
- Latency, with T = grant cycle:
  - Fetch, load, full-word store, error: ready at T+1.
  - Sub-word store: ready at T+2.
  - A requester held off by a tie is granted at T+2, the next IDLE cycle.
- Requesters: hold req and all qualifiers stable until ready. A req still high in the cycle after ready is a new request.
- Error and ready are never asserted outside response cycles; imem_ready and dmem_ready are never asserted together.

Decomposition:
- defs_pkg: add arb_state_t (IDLE, I_RESP, D_RESP, D_MERGE) and owner_t (INST, DATA). Reuse the existing BYTE/HALF/WORD/DOUBLE size codes.
- One combinational sub-module, mem_lane_align: load extract/extend and store merge, parameterised on XLEN.

Test Plan:
- Fetch: word0=0x1111_2222_3333_4444 (XLEN=64), reset release, imem_addr=0x4 → imem_ready at T+1, imem_data=0x1111_2222, err=0. Outputs are all 0 during reset.
- Tie: imem_req and dmem_read_req both rise on the first cycle after reset → dmem_ready at T+1, imem_ready at T+3. A second tie → imem served first.
- Byte loads: word2=0x0000_0000_8000_0000, LB at addr 0x13 → dmem_rdata=0xFFFF_FFFF_FFFF_FF80. Same access as LBU → 0x0000_0000_0000_0080.
- Sub-word store: word1=0xAAAA_AAAA_AAAA_AAAA, SH addr 0x0A wdata 0xBEEF → one sram_we pulse at T+1 with data 0xAAAA_AAAA_BEEF_AAAA; dmem_ready at T+2; read-back matches.
- Errors: LW at addr 0x6 → dmem_err=1, dmem_rdata=0, ready T+1, no sram_we. Load at addr 0x20_0000 → out-of-range error. imem_addr=0x2 → imem_err=1.
- Reset during D_MERGE: no sram_we is seen and the word is unchanged. After release, the next fetch is served normally with latency T+1.

Source files
------------

// File: rtl/defs_pkg.sv
// Shared memory-access definitions: size codes, arbiter state and owner types,
// and the alignment check used by the SRAM port arbiter.
package defs_pkg;

  localparam logic [2:0] BYTE   = 3'd0;
  localparam logic [2:0] HALF   = 3'd1;
  localparam logic [2:0] WORD   = 3'd2;
  localparam logic [2:0] DOUBLE = 3'd3;

  typedef enum logic [1:0] {IDLE, I_RESP, D_RESP, D_MERGE} arb_state_t;
  typedef enum logic {INST, DATA} owner_t;

  // Unknown size codes are treated as misaligned so they surface as errors.
  function automatic logic misaligned(input logic [2:0] size, input logic [2:0] off);
    case (size)
      BYTE:    misaligned = 1'b0;
      HALF:    misaligned = off[0];
      WORD:    misaligned = |off[1:0];
      DOUBLE:  misaligned = |off;
      default: misaligned = 1'b1;
    endcase
  endfunction

endpackage

// File: rtl/mem_lane_align.sv
// Little-endian lane handling: load extract with sign/zero extension and
// sub-word store merge into a full SRAM word.
module mem_lane_align
  import defs_pkg::*;
#(
  parameter int XLEN = 64,
  parameter int OFFW = $clog2(XLEN/8)
) (
  input  logic [XLEN-1:0] rdata,
  input  logic [XLEN-1:0] wdata,
  input  logic [OFFW-1:0] off,
  input  logic [2:0]      size,
  input  logic            sgn,
  output logic [XLEN-1:0] load_data,
  output logic [XLEN-1:0] merged
);
  logic [OFFW+2:0] shamt;
  logic [XLEN-1:0] shifted;
  logic [XLEN-1:0] lmask;
  logic            sbit;

  always_comb begin
    shamt   = {off, 3'b000};
    shifted = rdata >> shamt;
    lmask   = '1;
    sbit    = shifted[XLEN-1];
    case (size)
      BYTE: begin lmask = XLEN'(8'hFF);         sbit = shifted[7];  end
      HALF: begin lmask = XLEN'(16'hFFFF);      sbit = shifted[15]; end
      WORD: begin lmask = XLEN'(32'hFFFF_FFFF); sbit = shifted[31]; end
      default: ;
    endcase
    load_data = (shifted & lmask) | ({XLEN{sgn & sbit}} & ~lmask);
    merged    = (rdata & ~(lmask << shamt)) | ((wdata & lmask) << shamt);
  end

endmodule

// File: rtl/sram_port_arbiter.sv
// Fetch/LSU arbiter for the single-port main SRAM: round-robin on ties,
// alignment/range checks, read-modify-write for sub-word stores.
module sram_port_arbiter
  import defs_pkg::*;
#(
  parameter int XLEN      = 64,
  parameter int MEM_DEPTH = 262144
) (
  input  logic                         clk,
  input  logic                         resetn,
  input  logic                         imem_req,
  input  logic [31:0]                  imem_addr,
  output logic                         imem_ready,
  output logic                         imem_err,
  output logic [31:0]                  imem_data,
  input  logic                         dmem_read_req,
  input  logic                         dmem_write_req,
  input  logic [XLEN-1:0]              dmem_addr,
  input  logic [XLEN-1:0]              dmem_wdata,
  input  logic [2:0]                   dmem_size,
  input  logic                         dmem_signed,
  output logic [XLEN-1:0]              dmem_rdata,
  output logic                         dmem_ready,
  output logic                         dmem_err,
  output logic                         sram_we,
  output logic [$clog2(MEM_DEPTH)-1:0] sram_addr,
  output logic [XLEN-1:0]              sram_wdata,
  input  logic [XLEN-1:0]              sram_rdata
);
  localparam int         AW        = $clog2(MEM_DEPTH);
  localparam int         OFFW      = $clog2(XLEN/8);
  localparam logic [2:0] FULL_SIZE = (XLEN == 64) ? DOUBLE : WORD;

  arb_state_t      state_q, state_d;
  owner_t          last_q, last_d;
  logic [AW-1:0]   idx_q, idx_d;
  logic [OFFW-1:0] off_q, off_d;
  logic [2:0]      size_q, size_d;
  logic            sgn_q, sgn_d;
  logic [XLEN-1:0] wdata_q, wdata_d;
  logic            write_q, write_d;
  logic            err_q, err_d;

  logic            d_req, tie, i_err, d_err, grant_i, grant_d;
  logic [XLEN-1:0] load_data, merged;

  assign d_req   = dmem_read_req | dmem_write_req;
  assign tie     = imem_req & d_req;
  assign i_err   = (|(imem_addr >> (OFFW + AW))) | (|imem_addr[1:0]);
  assign d_err   = (|(dmem_addr >> (OFFW + AW)))
                 | misaligned(dmem_size, 3'(dmem_addr[OFFW-1:0]))
                 | ((dmem_size == DOUBLE) && (XLEN == 32));
  // Data wins a tie unless it won the previous one.
  assign grant_d = (state_q == IDLE) & resetn & d_req & (!imem_req | (last_q == INST));
  assign grant_i = (state_q == IDLE) & resetn & imem_req & !grant_d;

  always_comb begin
    state_d    = state_q;
    last_d     = last_q;
    idx_d      = idx_q;
    off_d      = off_q;
    size_d     = size_q;
    sgn_d      = sgn_q;
    wdata_d    = wdata_q;
    write_d    = write_q;
    err_d      = err_q;
    sram_we    = 1'b0;
    sram_addr  = '0;
    sram_wdata = '0;
    case (state_q)
      IDLE: begin
        if (grant_i) begin
          // Fetch reuses the load path as an unsigned 32-bit lane.
          state_d = I_RESP;
          idx_d   = imem_addr[OFFW +: AW];
          off_d   = imem_addr[OFFW-1:0];
          size_d  = WORD;
          sgn_d   = 1'b0;
          wdata_d = '0;
          write_d = 1'b0;
          err_d   = i_err;
          if (tie) last_d = INST;
          if (!i_err) sram_addr = imem_addr[OFFW +: AW];
        end else if (grant_d) begin
          idx_d   = dmem_addr[OFFW +: AW];
          off_d   = dmem_addr[OFFW-1:0];
          size_d  = dmem_size;
          sgn_d   = dmem_signed;
          wdata_d = dmem_wdata;
          write_d = !dmem_read_req;
          err_d   = d_err;
          state_d = D_RESP;
          if (tie) last_d = DATA;
          if (!d_err) begin
            sram_addr = dmem_addr[OFFW +: AW];
            if (!dmem_read_req && dmem_size == FULL_SIZE) begin
              sram_we    = 1'b1;
              sram_wdata = dmem_wdata;
            end else if (!dmem_read_req) begin
              state_d = D_MERGE;
            end
          end
        end
      end
      D_MERGE: begin
        sram_we    = 1'b1;
        sram_addr  = idx_q;
        sram_wdata = merged;
        state_d    = D_RESP;
      end
      default: state_d = IDLE;
    endcase
    if (!resetn) begin
      sram_we    = 1'b0;
      sram_addr  = '0;
      sram_wdata = '0;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= IDLE;
      last_q  <= INST;
      idx_q   <= '0;
      off_q   <= '0;
      size_q  <= '0;
      sgn_q   <= 1'b0;
      wdata_q <= '0;
      write_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      idx_q   <= idx_d;
      off_q   <= off_d;
      size_q  <= size_d;
      sgn_q   <= sgn_d;
      wdata_q <= wdata_d;
      write_q <= write_d;
      err_q   <= err_d;
    end
  end

  mem_lane_align #(.XLEN(XLEN), .OFFW(OFFW)) u_align (
    .rdata     (sram_rdata),
    .wdata     (wdata_q),
    .off       (off_q),
    .size      (size_q),
    .sgn       (sgn_q),
    .load_data (load_data),
    .merged    (merged)
  );

  assign imem_ready = (state_q == I_RESP);
  assign imem_err   = imem_ready & err_q;
  assign imem_data  = (imem_ready && !err_q) ? load_data[31:0] : '0;
  assign dmem_ready = (state_q == D_RESP);
  assign dmem_err   = dmem_ready & err_q;
  assign dmem_rdata = (dmem_ready && !err_q && !write_q) ? load_data : '0;

endmodule

// File: tb/tb_sram_port_arbiter.sv
// Directed bench for sram_port_arbiter with a behavioural 1-cycle SRAM and
// per-port expected-response queues checked on each ready pulse.
module tb_sram_port_arbiter;
  import defs_pkg::*;

  localparam int XLEN      = 64;
  localparam int MEM_DEPTH = 262144;
  localparam int AW        = 18;

  logic            clk = 1'b0;
  logic            resetn;
  logic            imem_req;
  logic [31:0]     imem_addr;
  logic            imem_ready, imem_err;
  logic [31:0]     imem_data;
  logic            dmem_read_req, dmem_write_req;
  logic [XLEN-1:0] dmem_addr, dmem_wdata, dmem_rdata;
  logic [2:0]      dmem_size;
  logic            dmem_signed;
  logic            dmem_ready, dmem_err;
  logic            sram_we;
  logic [AW-1:0]   sram_addr;
  logic [XLEN-1:0] sram_wdata, sram_rdata;

  always #5 clk = ~clk;

  sram_port_arbiter #(.XLEN(XLEN), .MEM_DEPTH(MEM_DEPTH)) dut (
    .clk            (clk),
    .resetn         (resetn),
    .imem_req       (imem_req),
    .imem_addr      (imem_addr),
    .imem_ready     (imem_ready),
    .imem_err       (imem_err),
    .imem_data      (imem_data),
    .dmem_read_req  (dmem_read_req),
    .dmem_write_req (dmem_write_req),
    .dmem_addr      (dmem_addr),
    .dmem_wdata     (dmem_wdata),
    .dmem_size      (dmem_size),
    .dmem_signed    (dmem_signed),
    .dmem_rdata     (dmem_rdata),
    .dmem_ready     (dmem_ready),
    .dmem_err       (dmem_err),
    .sram_we        (sram_we),
    .sram_addr      (sram_addr),
    .sram_wdata     (sram_wdata),
    .sram_rdata     (sram_rdata)
  );

  // SRAM model with a preload port usable while the DUT is held in reset.
  logic [63:0]   mem [0:MEM_DEPTH-1];
  logic          pl_en;
  logic [AW-1:0] pl_addr;
  logic [63:0]   pl_data;
  always @(posedge clk) begin
    if (pl_en) mem[pl_addr] <= pl_data;
    else if (sram_we) mem[sram_addr] <= sram_wdata;
    sram_rdata <= mem[sram_addr];
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int            we_cnt = 0;
  logic [63:0]   we_data = '0;
  logic [AW-1:0] we_addr = '0;
  always @(negedge clk) begin
    if (sram_we) begin
      we_cnt  <= we_cnt + 1;
      we_data <= sram_wdata;
      we_addr <= sram_addr;
    end
  end

  typedef struct {
    logic [63:0] data;
    logic        err;
    int          cyc;
  } exp_t;
  exp_t iq[$];
  exp_t dq[$];

  int checks = 0;
  int failures = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic issue_i(input logic [31:0] a, input logic [63:0] ed, input logic ee,
                         input int lat);
    exp_t e;
    imem_addr = a;
    imem_req  = 1'b1;
    e.data = ed; e.err = ee; e.cyc = cyc + lat;
    iq.push_back(e);
  endtask

  task automatic issue_d(input logic wr, input logic [63:0] a, input logic [2:0] sz,
                         input logic sg, input logic [63:0] wd, input logic [63:0] ed,
                         input logic ee, input int lat);
    exp_t e;
    dmem_addr      = a;
    dmem_size      = sz;
    dmem_signed    = sg;
    dmem_wdata     = wd;
    dmem_read_req  = !wr;
    dmem_write_req = wr;
    e.data = ed; e.err = ee; e.cyc = cyc + lat;
    dq.push_back(e);
  endtask

  // Step cycle by cycle until every queued response has been seen or the budget expires.
  task automatic run(input int budget);
    exp_t e;
    logic gi, gd;
    int   n;
    n = 0;
    while ((iq.size() + dq.size()) != 0 && n < budget) begin
      @(negedge clk);
      gi = imem_ready;
      gd = dmem_ready;
      chk("excl", {61'd0, gi & gd, imem_err & !gi, dmem_err & !gd}, 64'd0);
      if (gi) begin
        if (iq.size() == 0) chk("spurious_i", 64'(gi), 64'd0);
        else begin
          e = iq.pop_front();
          chk("i_data", 64'(imem_data), e.data);
          chk("i_err", 64'(imem_err), 64'(e.err));
          chk("i_lat", 64'(cyc), 64'(e.cyc));
        end
      end
      if (gd) begin
        if (dq.size() == 0) chk("spurious_d", 64'(gd), 64'd0);
        else begin
          e = dq.pop_front();
          chk("d_data", dmem_rdata, e.data);
          chk("d_err", 64'(dmem_err), 64'(e.err));
          chk("d_lat", 64'(cyc), 64'(e.cyc));
        end
      end
      @(posedge clk); #1;
      if (gi) imem_req = 1'b0;
      if (gd) begin
        dmem_read_req  = 1'b0;
        dmem_write_req = 1'b0;
      end
      n++;
    end
    chk("drain", 64'(iq.size() + dq.size()), 64'd0);
    iq.delete();
    dq.delete();
  endtask

  task automatic preload(input logic [AW-1:0] a, input logic [63:0] d);
    pl_addr = a;
    pl_data = d;
    @(posedge clk); #1;
  endtask

  initial begin
    int we0;
    resetn = 1'b0;
    imem_req = 1'b0; imem_addr = '0;
    dmem_read_req = 1'b0; dmem_write_req = 1'b0;
    dmem_addr = '0; dmem_wdata = '0; dmem_size = BYTE; dmem_signed = 1'b0;
    pl_en = 1'b0; pl_addr = '0; pl_data = '0;

    // Requests held high during reset must not leak to any output.
    imem_req = 1'b1; imem_addr = 32'h4;
    dmem_write_req = 1'b1; dmem_size = DOUBLE; dmem_addr = 64'h8; dmem_wdata = '1;
    pl_en = 1'b1;
    preload(18'd0, 64'h1111_2222_3333_4444);
    preload(18'd1, 64'hAAAA_AAAA_AAAA_AAAA);
    preload(18'd2, 64'h0000_0000_8000_0000);
    pl_en = 1'b0;
    @(negedge clk);
    chk("rst_ctl", 64'({imem_ready, imem_err, dmem_ready, dmem_err, sram_we}), 64'd0);
    chk("rst_idata", 64'(imem_data), 64'd0);
    chk("rst_drdata", dmem_rdata, 64'd0);
    chk("rst_saddr", 64'(sram_addr), 64'd0);
    chk("rst_swdata", sram_wdata, 64'd0);
    chk("rst_we_cnt", 64'(we_cnt), 64'd0);
    imem_req = 1'b0; dmem_write_req = 1'b0;
    @(negedge clk); resetn = 1'b1;
    @(posedge clk); #1;

    issue_i(32'h4, 64'h1111_2222, 1'b0, 1);
    run(10);

    // Tie with last_grant=INST: data first, fetch two cycles later.
    issue_i(32'h0, 64'h3333_4444, 1'b0, 3);
    issue_d(1'b0, 64'h8, DOUBLE, 1'b0, 64'h0, 64'hAAAA_AAAA_AAAA_AAAA, 1'b0, 1);
    run(10);
    // Second tie flips to fetch first.
    issue_i(32'h4, 64'h1111_2222, 1'b0, 1);
    issue_d(1'b0, 64'h13, BYTE, 1'b1, 64'h0, 64'hFFFF_FFFF_FFFF_FF80, 1'b0, 3);
    run(10);
    issue_d(1'b0, 64'h13, BYTE, 1'b0, 64'h0, 64'h0000_0000_0000_0080, 1'b0, 1);
    run(10);

    we0 = we_cnt;
    issue_d(1'b1, 64'h0A, HALF, 1'b0, 64'h1234_5678_9ABC_BEEF, 64'h0, 1'b0, 2);
    run(10);
    chk("sh_we_cnt", 64'(we_cnt - we0), 64'd1);
    chk("sh_we_data", we_data, 64'hAAAA_AAAA_BEEF_AAAA);
    chk("sh_we_addr", 64'(we_addr), 64'd1);
    issue_d(1'b0, 64'h8, DOUBLE, 1'b0, 64'h0, 64'hAAAA_AAAA_BEEF_AAAA, 1'b0, 1);
    run(10);

    we0 = we_cnt;
    issue_d(1'b1, 64'h18, DOUBLE, 1'b0, 64'h0123_4567_89AB_CDEF, 64'h0, 1'b0, 1);
    run(10);
    chk("sd_we_cnt", 64'(we_cnt - we0), 64'd1);
    issue_d(1'b0, 64'h18, HALF, 1'b1, 64'h0, 64'hFFFF_FFFF_FFFF_CDEF, 1'b0, 1);
    run(10);
    issue_d(1'b0, 64'h1C, WORD, 1'b1, 64'h0, 64'h0000_0000_0123_4567, 1'b0, 1);
    run(10);
    issue_d(1'b0, 64'h18, WORD, 1'b1, 64'h0, 64'hFFFF_FFFF_89AB_CDEF, 1'b0, 1);
    run(10);
    issue_d(1'b0, 64'h1F, BYTE, 1'b0, 64'h0, 64'h0000_0000_0000_0001, 1'b0, 1);
    run(10);

    we0 = we_cnt;
    issue_d(1'b0, 64'h6, WORD, 1'b0, 64'h0, 64'h0, 1'b1, 1);
    run(10);
    issue_d(1'b0, 64'h20_0000, DOUBLE, 1'b0, 64'h0, 64'h0, 1'b1, 1);
    run(10);
    issue_d(1'b1, 64'h21, HALF, 1'b0, 64'hFFFF, 64'h0, 1'b1, 1);
    run(10);
    chk("err_no_we", 64'(we_cnt - we0), 64'd0);
    issue_i(32'h2, 64'h0, 1'b1, 1);
    run(10);

    // Reset while the merge write is pending: write and response are dropped.
    we0 = we_cnt;
    issue_d(1'b1, 64'h10, BYTE, 1'b0, 64'h55, 64'h0, 1'b0, 2);
    @(posedge clk); #1;
    resetn = 1'b0;
    dmem_write_req = 1'b0;
    dq.delete();
    repeat (3) begin
      @(negedge clk);
      chk("rst_no_resp", 64'({dmem_ready, imem_ready, sram_we}), 64'd0);
    end
    chk("rst_merge_we", 64'(we_cnt - we0), 64'd0);
    @(negedge clk); resetn = 1'b1;
    @(posedge clk); #1;
    issue_i(32'h4, 64'h1111_2222, 1'b0, 1);
    run(10);
    issue_d(1'b0, 64'h10, DOUBLE, 1'b0, 64'h0, 64'h0000_0000_8000_0000, 1'b0, 1);
    run(10);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

endmodule
